// File: rtl/lsu_subword.sv
`default_nettype none
// ============================================================================
// Module      : lsu_subword
// Description : Load/store unit in front of a word-wide byte-array data memory.
//               Handles byte and halfword loads with sign or zero extension.
//               Byte and halfword stores use a read-modify-write sequence,
//               because the memory only writes full words.
//               Optional build macro LSU_MISALIGN_EN enables misalignment
//               flagging. Misaligned accesses then complete with err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_subword #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [2:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    localparam logic [2:0] c_op_lb  = 3'd0;
    localparam logic [2:0] c_op_lh  = 3'd1;
    localparam logic [2:0] c_op_lw  = 3'd2;
    localparam logic [2:0] c_op_sb  = 3'd3;
    localparam logic [2:0] c_op_lbu = 3'd4;
    localparam logic [2:0] c_op_lhu = 3'd5;
    localparam logic [2:0] c_op_sh  = 3'd6;
    localparam logic [2:0] c_op_sw  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_op;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merge;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic                w_accept;
    logic                w_misalign;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [31:0]         w_merge;
    logic                w_unused;

    // Upper address bits lie outside the memory and are deliberately dropped.
    assign w_unused = &{1'b0, addr[31:ADDR_W]};

    assign w_accept = req && (r_state == S_IDLE);

`ifdef LSU_MISALIGN_EN
    // Flag halfword accesses on odd addresses and word accesses off a word boundary.
    always_comb begin
        w_misalign = 1'b0;
        case (op)
            c_op_lh, c_op_lhu, c_op_sh: w_misalign = addr[0];
            c_op_lw, c_op_sw:           w_misalign = |addr[1:0];
            default:                    w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // State register; reset aborts whatever access is in flight.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state selection from the accepted op and the current step.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_next = S_RESP;
                    end else begin
                        case (op)
                            c_op_sw:          w_next = S_WRITE;
                            c_op_sb, c_op_sh: w_next = S_RMW_RD;
                            default:          w_next = S_LOAD;
                        endcase
                    end
                end
            end
            S_LOAD:   w_next = S_RESP;
            S_RMW_RD: w_next = S_WRITE;
            S_WRITE:  w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Lane extraction and extension of the word read from memory.
    always_comb begin
        w_byte = dm_dout[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = dm_dout[15:8];
            2'd2:    w_byte = dm_dout[23:16];
            2'd3:    w_byte = dm_dout[31:24];
            default: w_byte = dm_dout[7:0];
        endcase
        w_half = r_addr[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (r_op)
            c_op_lb:  w_load = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_load = {24'd0, w_byte};
            c_op_lh:  w_load = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_load = {16'd0, w_half};
            default:  w_load = dm_dout;
        endcase
    end

    // Overlay the store lane onto the word read back, keeping the other bytes.
    always_comb begin
        w_merge = dm_dout;
        if (r_op == c_op_sb)
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else if (r_op == c_op_sh)
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    // Request latching, merge capture, load result and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_op    <= '0;
            r_wdata <= '0;
            r_merge <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr[ADDR_W-1:0];
                r_op    <= op;
                r_wdata <= wdata;
                r_err   <= w_misalign;
            end
            if (r_state == S_LOAD)   r_rdata <= w_load;
            if (r_state == S_RMW_RD) r_merge <= w_merge;
        end
    end

    assign ready   = (r_state == S_IDLE);
    assign done    = (r_state == S_RESP);
    assign err     = done && r_err;
    assign rdata   = r_rdata;
    assign dm_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign dm_din  = (r_op == c_op_sw) ? r_wdata : r_merge;
    assign dm_we   = (r_state == S_WRITE) && !rst;

endmodule
`default_nettype wire
